interval_timer: RTL and testbench

- Countdown timer for the traffic-light controller: consumes startTimer/timeParameter and returns expired.
- Holds three reprogrammable interval registers (base, extended, yellow) plus a fixed zero interval, and counts whole seconds using an internal prescaler.
- Sits beside the controller FSM; its interval registers are written by the reprogram path.

---
 rtl/interval_timer.sv | 143 ++++++++++++++
 tb/tb_interval_timer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// interval_timer: whole-second countdown for the traffic-light controller.
// Three reprogrammable intervals (base, extended, yellow) plus a fixed zero
// interval; a prescaler turns CLK_PER_SEC clock cycles into one tick.
module interval_timer #(
  parameter int CLK_PER_SEC  = 50000000,
  parameter int WIDTH        = 4,
  parameter int BASE_DEFAULT = 6,
  parameter int EXT_DEFAULT  = 3,
  parameter int YEL_DEFAULT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startTimer,
  input  logic [1:0]       timeParameter,
  input  logic             prog_en,
  input  logic [1:0]       prog_sel,
  input  logic [WIDTH-1:0] prog_value,
  output logic             expired,
  output logic             busy,
  output logic [WIDTH-1:0] remaining
);

  localparam int PS_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PS_W-1:0]  PS_MAX    = PS_W'(CLK_PER_SEC - 1);
  localparam logic [WIDTH-1:0] BASE_INIT = WIDTH'(BASE_DEFAULT);
  localparam logic [WIDTH-1:0] EXT_INIT  = WIDTH'(EXT_DEFAULT);
  localparam logic [WIDTH-1:0] YEL_INIT  = WIDTH'(YEL_DEFAULT);
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             expired_q, expired_d;
  logic             zero_pend_q, zero_pend_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] ext_q, ext_d;
  logic [WIDTH-1:0] yel_q, yel_d;
  logic [WIDTH-1:0] sel_val;

  // Interval selected by timeParameter; reads the registers before any
  // same-cycle write lands, so a simultaneous start sees the old value.
  always_comb begin
    sel_val = '0;
    case (timeParameter)
      2'b00:   sel_val = base_q;
      2'b01:   sel_val = ext_q;
      2'b10:   sel_val = yel_q;
      default: sel_val = '0;
    endcase
  end

  // Reprogram path: selector 11 addresses the fixed zero interval and is dropped.
  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    if (prog_en) begin
      case (prog_sel)
        2'b00:   base_d = prog_value;
        2'b01:   ext_d  = prog_value;
        2'b10:   yel_d  = prog_value;
        default: ;
      endcase
    end
  end

  // Next-state logic: a start always wins over a pending zero pulse or a
  // final tick, which also keeps expired from ever lasting two cycles.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ps_d        = ps_q;
    expired_d   = 1'b0;
    zero_pend_d = 1'b0;
    if (startTimer) begin
      count_d = sel_val;
      ps_d    = '0;
      if (sel_val != '0) begin
        state_d = COUNT;
      end else begin
        state_d     = IDLE;
        zero_pend_d = 1'b1;
      end
    end else if (zero_pend_q) begin
      expired_d = 1'b1;
    end else begin
      case (state_q)
        COUNT: begin
          if (ps_q == PS_MAX) begin
            ps_d = '0;
            if (count_q <= CNT_ONE) begin
              count_d   = '0;
              expired_d = 1'b1;
              state_d   = IDLE;
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end else begin
            ps_d = ps_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Timer state registers; reset aborts any count without a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ps_q        <= '0;
      expired_q   <= 1'b0;
      zero_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ps_q        <= ps_d;
      expired_q   <= expired_d;
      zero_pend_q <= zero_pend_d;
    end
  end

  // Interval registers, restored to their defaults on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= BASE_INIT;
      ext_q  <= EXT_INIT;
      yel_q  <= YEL_INIT;
    end else begin
      base_q <= base_d;
      ext_q  <= ext_d;
      yel_q  <= yel_d;
    end
  end

  assign expired   = expired_q;
  assign busy      = (state_q == COUNT);
  assign remaining = count_q;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer with CLK_PER_SEC=4: a vector table of
// {program, select, expected interval/latency} plus hand-written sequences
// for restart, reset abort, start/tick collision and a controller loop.
module tb_interval_timer;

  localparam int CPS = 4;
  localparam int W   = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         startTimer;
  logic [1:0]   timeParameter;
  logic         prog_en;
  logic [1:0]   prog_sel;
  logic [W-1:0] prog_value;
  logic         expired;
  logic         busy;
  logic [W-1:0] remaining;

  int checks = 0;
  int errors = 0;
  int double_cnt = 0;
  logic prev_exp = 1'b0;

  always #5 clk = ~clk;

  interval_timer #(
    .CLK_PER_SEC (CPS),
    .WIDTH       (W),
    .BASE_DEFAULT(6),
    .EXT_DEFAULT (3),
    .YEL_DEFAULT (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startTimer   (startTimer),
    .timeParameter(timeParameter),
    .prog_en      (prog_en),
    .prog_sel     (prog_sel),
    .prog_value   (prog_value),
    .expired      (expired),
    .busy         (busy),
    .remaining    (remaining)
  );

  // Watch for expired staying high on two consecutive sampled cycles.
  always @(negedge clk) begin
    if (expired === 1'b1 && prev_exp === 1'b1) double_cnt = double_cnt + 1;
    prev_exp = expired;
  end

  typedef struct {
    bit         rst_before;
    bit         do_prog;
    logic [1:0] psel;
    logic [3:0] pval;
    logic [1:0] tp;
    int         n;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int m, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s m=%0d actual=%0d required=%0d", name, m, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    startTimer = 1'b0;
    prog_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic program_reg(input logic [1:0] sel, input logic [3:0] val);
    prog_sel = sel;
    prog_value = val;
    prog_en = 1'b1;
    @(negedge clk);
    prog_en = 1'b0;
  endtask

  // Raise startTimer for one edge; returns at the negedge after that edge.
  task automatic pulse_start(input logic [1:0] tp);
    timeParameter = tp;
    startTimer = 1'b1;
    @(negedge clk);
    startTimer = 1'b0;
  endtask

  // m counts edges since the start edge; lat=0 means no pulse expected.
  task automatic watch(input string name, input int lat, input int n, input int ncyc);
    int exp_e, exp_b, exp_r;
    for (int m = 0; m <= ncyc; m++) begin
      if (m > 0) @(negedge clk);
      exp_e = (lat != 0 && m == lat) ? 1 : 0;
      exp_b = (n != 0 && (lat == 0 || m < lat)) ? 1 : 0;
      exp_r = (n == 0 || (lat != 0 && m >= lat)) ? 0 : n - m / CPS;
      check({name, ".expired"}, m, {31'd0, expired}, exp_e);
      check({name, ".busy"}, m, {31'd0, busy}, exp_b);
      check({name, ".remaining"}, m, {28'd0, remaining}, exp_r);
    end
  endtask

  vec_t vecs[10];
  logic [1:0] ctrl_tp[5];
  int         ctrl_n[5];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'b00, 4'd0,  2'b00, 6,  24};
    vecs[1] = '{1'b0, 1'b0, 2'b00, 4'd0,  2'b11, 0,  1};
    vecs[2] = '{1'b0, 1'b0, 2'b00, 4'd0,  2'b10, 2,  8};
    vecs[3] = '{1'b0, 1'b0, 2'b00, 4'd0,  2'b01, 3,  12};
    vecs[4] = '{1'b0, 1'b1, 2'b01, 4'd5,  2'b01, 5,  20};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 4'd0,  2'b01, 3,  12};
    vecs[6] = '{1'b0, 1'b1, 2'b11, 4'd9,  2'b11, 0,  1};
    vecs[7] = '{1'b0, 1'b1, 2'b00, 4'd0,  2'b00, 0,  1};
    vecs[8] = '{1'b0, 1'b1, 2'b10, 4'd15, 2'b10, 15, 60};
    vecs[9] = '{1'b1, 1'b0, 2'b00, 4'd0,  2'b00, 6,  24};

    ctrl_tp[0] = 2'b00; ctrl_n[0] = 6;
    ctrl_tp[1] = 2'b10; ctrl_n[1] = 2;
    ctrl_tp[2] = 2'b01; ctrl_n[2] = 3;
    ctrl_tp[3] = 2'b10; ctrl_n[3] = 2;
    ctrl_tp[4] = 2'b00; ctrl_n[4] = 6;

    reset = 1'b1;
    startTimer = 1'b0;
    timeParameter = 2'b00;
    prog_en = 1'b0;
    prog_sel = 2'b00;
    prog_value = '0;
    @(negedge clk);
    check("reset.expired", 0, {31'd0, expired}, 0);
    check("reset.busy", 0, {31'd0, busy}, 0);
    check("reset.remaining", 0, {28'd0, remaining}, 0);
    reset = 1'b0;

    // Table-driven intervals, programming and reset restore.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst_before) do_reset();
      if (vecs[i].do_prog) program_reg(vecs[i].psel, vecs[i].pval);
      pulse_start(vecs[i].tp);
      watch($sformatf("vec%0d", i), vecs[i].lat, vecs[i].n, vecs[i].lat + 6);
    end

    // Restart with YEL at cycle 10 of a BASE count.
    do_reset();
    pulse_start(2'b00);
    watch("restart_a", 0, 6, 9);
    pulse_start(2'b10);
    watch("restart_b", 8, 2, 20);

    // Reset at cycle 7 of a BASE count.
    pulse_start(2'b00);
    watch("abort_a", 0, 6, 7);
    reset = 1'b1;
    #1;
    check("abort.busy", 7, {31'd0, busy}, 0);
    check("abort.remaining", 7, {28'd0, remaining}, 0);
    check("abort.expired", 7, {31'd0, expired}, 0);
    @(negedge clk);
    reset = 1'b0;
    watch("abort_b", 0, 0, 40);

    // Start on the same edge as the final tick: no pulse for the old count.
    pulse_start(2'b10);
    watch("tie_a", 0, 2, 7);
    pulse_start(2'b10);
    watch("tie_b", 8, 2, 12);

    // Write and start on the same edge: start uses the old base value.
    prog_sel = 2'b00;
    prog_value = 4'd2;
    prog_en = 1'b1;
    timeParameter = 2'b00;
    startTimer = 1'b1;
    @(negedge clk);
    prog_en = 1'b0;
    startTimer = 1'b0;
    watch("progstart", 24, 6, 26);
    pulse_start(2'b00);
    watch("newbase", 8, 2, 10);

    // Held startTimer with ZERO select never expires.
    timeParameter = 2'b11;
    startTimer = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held.expired", i, {31'd0, expired}, 0);
    end
    startTimer = 1'b0;
    watch("heldrel", 1, 0, 4);

    // Controller loop: advance to the next phase on each expired pulse.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      pulse_start(ctrl_tp[p]);
      watch($sformatf("ctrl%0d", p), ctrl_n[p] * CPS, ctrl_n[p], ctrl_n[p] * CPS);
    end
    @(negedge clk);
    check("expired.double", 0, double_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
